// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG word packer: pair-state encoding
// and default word/health-test sizes.
package trng_pkg;

  typedef enum logic {
    PAIR_FIRST  = 1'b0,
    PAIR_SECOND = 1'b1
  } pair_state_t;

  localparam int TRNG_WORD_W    = 8;
  localparam int TRNG_REP_LIMIT = 16;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: groups raw bits into pairs and emits the first bit
// of every unequal pair (10 -> 1, 01 -> 0); equal pairs emit nothing.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic rand_bit,
  output logic vn_bit,
  output logic vn_strobe
);

  pair_state_t pair_state;
  logic        first_bit;

  // Any idle cycle discards a half-collected pair so that pairs are always
  // made of two back-to-back samples.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pair_state <= PAIR_FIRST;
      first_bit  <= 1'b0;
    end else if (!en) begin
      pair_state <= PAIR_FIRST;
    end else begin
      case (pair_state)
        PAIR_FIRST: begin
          first_bit  <= rand_bit;
          pair_state <= PAIR_SECOND;
        end
        PAIR_SECOND: pair_state <= PAIR_FIRST;
        default:     pair_state <= PAIR_FIRST;
      endcase
    end
  end

  // The strobe is combinational on the second sample so the packer can
  // absorb the bit on the very edge that captures it.
  assign vn_strobe = en && (pair_state == PAIR_SECOND) && (first_bit != rand_bit);
  assign vn_bit    = first_bit;

endmodule

// File: rtl/trng_word_packer.sv
// Repetition-count health test, MSB-first word packing of debiased bits and
// a valid/ready output register with sticky overrun reporting.
module trng_word_packer
  import trng_pkg::*;
#(
  parameter int WIDTH     = TRNG_WORD_W,
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             rand_bit,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             health_fail,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  logic             vn_bit;
  logic             vn_strobe;

  logic             prev_bit;
  logic             prev_valid;
  logic [RW-1:0]    rep_cnt;
  logic [RW-1:0]    rep_next;
  logic             health_next;

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] new_word;
  logic             word_done;
  logic             load_word;
  logic             drop_word;

  trng_vn_debias u_debias (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .rand_bit  (rand_bit),
    .vn_bit    (vn_bit),
    .vn_strobe (vn_strobe)
  );

  always_comb begin
    rep_next = rep_cnt;
    if (en) begin
      if (!prev_valid || (rand_bit != prev_bit)) begin
        rep_next = RW'(1);
      end else if (rep_cnt != REP_MAX) begin
        rep_next = rep_cnt + RW'(1);
      end
    end
  end

  // The trip is visible on the same edge, so a word completing together
  // with the failing sample is already suppressed.
  assign health_next = health_fail || (en && (rep_next == REP_MAX));

  assign new_word  = {sreg[WIDTH-2:0], vn_bit};
  assign word_done = vn_strobe && (count == LAST_IDX);
  assign load_word = word_done && !health_next && (!word_valid || word_ready);
  assign drop_word = word_done && !health_next && word_valid && !word_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_bit    <= 1'b0;
      prev_valid  <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (en) begin
        prev_bit   <= rand_bit;
        prev_valid <= 1'b1;
      end
      rep_cnt     <= rep_next;
      health_fail <= health_next;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sreg  <= '0;
      count <= '0;
    end else if (vn_strobe) begin
      sreg  <= new_word;
      count <= word_done ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_word) begin
        word_data  <= new_word;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop_word) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trng_word_packer.sv
// Directed bench for trng_word_packer: reset, packing, discard, backpressure,
// health test and enable/reset control.
module tb_trng_word_packer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic       rand_bit;
  logic       word_ready;
  logic [7:0] word_data;
  logic       word_valid;
  logic       health_fail;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;

  trng_word_packer #(.WIDTH(8), .REP_LIMIT(16)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .en          (en),
    .rand_bit    (rand_bit),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_fail (health_fail),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic raw(input logic b);
    en       = 1'b1;
    rand_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One good pair carrying bit b: 1 -> raw 10, 0 -> raw 01
  task automatic send_bit(input logic b);
    raw(b);
    raw(~b);
  endtask

  task automatic send_bits(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n      = 1'b0;
    en         = 1'b1;
    rand_bit   = 1'b0;
    word_ready = 1'b1;

    // 1 Reset held with en=1 and toggling bits
    for (int i = 0; i < 4; i++) raw(i[0]);
    chk("rst_data", {24'd0, word_data}, 32'h0);
    chk("rst_valid", {31'd0, word_valid}, 32'h0);
    chk("rst_health", {31'd0, health_fail}, 32'h0);
    chk("rst_overrun", {31'd0, overrun}, 32'h0);
    clr_n = 1'b1;
    idle(); idle(); idle();
    chk("post_rst_valid", {31'd0, word_valid}, 32'h0);
    chk("post_rst_data", {24'd0, word_data}, 32'h0);

    // 2 Basic word 0xB2 = raw 10 01 10 10 01 01 10 01
    word_ready = 1'b1;
    send_bits(8'hB2, 7, 1);
    raw(1'b0);
    chk("basic_valid_early", {31'd0, word_valid}, 32'h0);
    raw(1'b1);
    chk("basic_valid", {31'd0, word_valid}, 32'h1);
    chk("basic_data", {24'd0, word_data}, 32'hB2);
    idle();
    chk("basic_valid_drop", {31'd0, word_valid}, 32'h0);

    // 3 Equal pairs are discarded
    for (int i = 0; i < 16; i++) begin
      raw(1'b0); raw(1'b0); raw(1'b1); raw(1'b1);
    end
    chk("discard_valid", {31'd0, word_valid}, 32'h0);
    chk("discard_health", {31'd0, health_fail}, 32'h0);
    chk("discard_overrun", {31'd0, overrun}, 32'h0);

    // 4 Backpressure: second word dropped while first is held
    word_ready = 1'b0;
    send_bits(8'h96, 7, 0);
    chk("bp_first_valid", {31'd0, word_valid}, 32'h1);
    chk("bp_first_data", {24'd0, word_data}, 32'h96);
    send_bits(8'h5A, 7, 1);
    chk("bp_hold_data", {24'd0, word_data}, 32'h96);
    chk("bp_overrun_early", {31'd0, overrun}, 32'h0);
    send_bit(1'b0);
    chk("bp_overrun", {31'd0, overrun}, 32'h1);
    chk("bp_hold_data2", {24'd0, word_data}, 32'h96);
    chk("bp_hold_valid", {31'd0, word_valid}, 32'h1);
    word_ready = 1'b1;
    idle();
    chk("bp_xfer_valid", {31'd0, word_valid}, 32'h0);
    chk("bp_overrun_sticky", {31'd0, overrun}, 32'h1);

    // Word completing on the edge of a transfer loads without overrun
    do_reset();
    chk("bp_rst_overrun", {31'd0, overrun}, 32'h0);
    word_ready = 1'b0;
    send_bits(8'h3C, 7, 0);
    chk("same_first_data", {24'd0, word_data}, 32'h3C);
    send_bits(8'hE1, 7, 1);
    raw(1'b1);
    chk("same_hold_data", {24'd0, word_data}, 32'h3C);
    word_ready = 1'b1;
    raw(1'b0);
    chk("same_valid", {31'd0, word_valid}, 32'h1);
    chk("same_data", {24'd0, word_data}, 32'hE1);
    chk("same_overrun", {31'd0, overrun}, 32'h0);
    idle();
    chk("same_drain", {31'd0, word_valid}, 32'h0);

    // 5 Health test trips on the 16th identical sample
    do_reset();
    for (int i = 0; i < 15; i++) raw(1'b1);
    chk("health_15", {31'd0, health_fail}, 32'h0);
    raw(1'b1);
    chk("health_16", {31'd0, health_fail}, 32'h1);
    send_bits(8'hA5, 7, 0);
    chk("health_no_word", {31'd0, word_valid}, 32'h0);
    chk("health_sticky", {31'd0, health_fail}, 32'h1);
    do_reset();
    for (int i = 0; i < 15; i++) raw(1'b1);
    raw(1'b0);
    chk("health_no_trip", {31'd0, health_fail}, 32'h0);

    // 6 en=0 after b0=1 drops the half pair; following 01 emits 0
    do_reset();
    raw(1'b1);
    idle();
    raw(1'b0);
    raw(1'b1);
    send_bits(8'h55, 6, 4);
    idle();
    send_bits(8'h55, 3, 0);
    chk("ctrl_valid", {31'd0, word_valid}, 32'h1);
    chk("ctrl_data", {24'd0, word_data}, 32'h55);
    idle();

    // Reset with 5 bits packed: a fresh 8 pairs are needed
    send_bits(8'hFF, 7, 3);
    do_reset();
    send_bits(8'hC3, 7, 1);
    chk("midrst_valid_early", {31'd0, word_valid}, 32'h0);
    send_bit(1'b1);
    chk("midrst_valid", {31'd0, word_valid}, 32'h1);
    chk("midrst_data", {24'd0, word_data}, 32'hC3);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
